// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------------------------------------------------------------------
// N-master to 1-slave memory-port arbiter. Several requesters (instruction
// fetch, load/store, debug/DMA) share one memory port. Arbitration is
// round-robin, the winning request is registered onto the slave port, and
// every transaction is bounded by a timeout that returns an error-ack if the
// slave never answers.
//
// Handshake (stb/ack): a master raises i_m_stb[k] together with its
// wr_en/addr/wdata and holds it as a level until it sees o_m_ack[k]. o_m_ack
// is a one-cycle pulse (at most one bit set), qualified by o_m_err and
// accompanied by o_m_rdata. On the slave side o_s_stb and o_s_* stay
// constant until the cycle in which i_s_ack=1 is sampled. i_s_rdata is only
// meaningful in that cycle.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   i_m_stb          per-master request strobe (level)
//   i_m_wr_en        per-master write enable (1=write)
//   i_m_addr         flattened addresses, master k at [k*ADDR_W +: ADDR_W]
//   i_m_wdata        flattened write data, master k at [k*DATA_W +: DATA_W]
//   o_m_ack          per-master completion pulse
//   o_m_err          qualifies o_m_ack, 1 = transaction timed out
//   o_m_rdata        shared read data, valid with o_m_ack
//   o_s_stb          slave strobe
//   o_s_wr_en        slave write enable
//   o_s_addr         slave address
//   o_s_wdata        slave write data
//   i_s_ack          slave completion
//   i_s_rdata        slave read data, sampled with i_s_ack
//   o_grant          one-hot owner of the slave port, 0 when idle
//   o_busy           1 while a transaction is outstanding (FSM state BUSY)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        i_m_stb,
  input  logic [NUM_MASTERS-1:0]        i_m_wr_en,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_m_wdata,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic [DATA_W-1:0]             o_m_rdata,
  output logic                          o_s_stb,
  output logic                          o_s_wr_en,
  output logic [ADDR_W-1:0]             o_s_addr,
  output logic [DATA_W-1:0]             o_s_wdata,
  input  logic                          i_s_ack,
  input  logic [DATA_W-1:0]             i_s_rdata,
  output logic [NUM_MASTERS-1:0]        o_grant,
  output logic                          o_busy
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]       TO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // FSM state; it is mirrored one-to-one on o_busy for observation.
  state_t           state;
  // Last master granted; during BUSY it is also the current owner.
  logic [PTR_W-1:0] rr_last;
  logic [CNT_W-1:0] to_cnt;

  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_valid;
  logic [PTR_W-1:0]       pick;
  logic                   timed_out;

  // A master being acked this cycle still shows its old stb; mask it so the
  // completed request is not granted a second time.
  assign eligible = i_m_stb & ~o_m_ack;

  // Round-robin search: first eligible master starting at rr_last+1, wrapping.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(rr_last) + i) % NUM_MASTERS;
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick       = PTR_W'(idx);
      end
    end
  end

  assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= PTR_W'(NUM_MASTERS - 1);
      to_cnt    <= '0;
      o_m_ack   <= '0;
      o_m_err   <= '0;
      o_m_rdata <= '0;
      o_s_stb   <= 1'b0;
      o_s_wr_en <= 1'b0;
      o_s_addr  <= '0;
      o_s_wdata <= '0;
      o_grant   <= '0;
      o_busy    <= 1'b0;
    end else begin
      // Ack/err are single-cycle pulses; o_m_rdata holds its last value.
      o_m_ack <= '0;
      o_m_err <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            o_s_stb   <= 1'b1;
            o_s_wr_en <= i_m_wr_en[pick];
            o_s_addr  <= i_m_addr[int'(pick)*ADDR_W +: ADDR_W];
            o_s_wdata <= i_m_wdata[int'(pick)*DATA_W +: DATA_W];
            o_grant   <= ONE_HOT0 << pick;
            o_busy    <= 1'b1;
            rr_last   <= pick;
            to_cnt    <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A real ack beats a simultaneous expiry.
          if (i_s_ack || timed_out) begin
            o_m_ack[rr_last] <= 1'b1;
            o_m_err[rr_last] <= ~i_s_ack;
            o_m_rdata        <= i_s_ack ? i_s_rdata : '0;
            o_s_stb          <= 1'b0;
            o_grant          <= '0;
            o_busy           <= 1'b0;
            state            <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Drives mem_bus_arbiter (3 masters, TIMEOUT=4) with directed and random
// batches of master requests. Each batch is planned by a transaction-level
// round-robin model that predicts the slave-side request order, the slave
// response for every transaction and the resulting master ack; a monitor
// compares the DUT against those queues as outputs appear.
module tb_mem_bus_arbiter;
  localparam int N     = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TO    = 4;
  localparam int NEVER = 255;
  localparam int EW    = 2 + 1 + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      i_m_stb;
  logic [N-1:0]      i_m_wr_en;
  logic [N*AW-1:0]   i_m_addr;
  logic [N*DW-1:0]   i_m_wdata;
  logic [N-1:0]      o_m_ack;
  logic [N-1:0]      o_m_err;
  logic [DW-1:0]     o_m_rdata;
  logic              o_s_stb;
  logic              o_s_wr_en;
  logic [AW-1:0]     o_s_addr;
  logic [DW-1:0]     o_s_wdata;
  logic              i_s_ack;
  logic [DW-1:0]     i_s_rdata;
  logic [N-1:0]      o_grant;
  logic              o_busy;

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_m_stb(i_m_stb), .i_m_wr_en(i_m_wr_en), .i_m_addr(i_m_addr), .i_m_wdata(i_m_wdata),
    .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_rdata(o_m_rdata),
    .o_s_stb(o_s_stb), .o_s_wr_en(o_s_wr_en), .o_s_addr(o_s_addr), .o_s_wdata(o_s_wdata),
    .i_s_ack(i_s_ack), .i_s_rdata(i_s_rdata),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    int            master;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dur;
  } exp_s_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] data;
  } resp_t;

  // exp_q entry: {master[1:0], err, rdata}
  logic [EW-1:0] exp_q[$];
  exp_s_t        exp_s_q[$];
  resp_t         resp_q[$];

  req_t          reqs[N][8];
  int            head[N];
  int            cnt[N];
  int            bcnt[N];
  int            txn_lat[32];
  logic [DW-1:0] txn_data[32];
  int            model_last;
  logic          late_ack;
  logic          in_txn;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- master driver ----------------
  // Each master presents the head of its request list and advances after its ack.
  initial begin
    logic [N-1:0] ackd;
    i_m_stb   = '0;
    i_m_wr_en = '0;
    i_m_addr  = '0;
    i_m_wdata = '0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      cnt[k]  = 0;
    end
    forever begin
      @(negedge clk);
      ackd = o_m_ack;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (ackd[k] && head[k] < cnt[k]) head[k]++;
        if (head[k] < cnt[k]) begin
          i_m_stb[k]               = 1'b1;
          i_m_wr_en[k]             = reqs[k][head[k]].wr;
          i_m_addr[k*AW +: AW]     = reqs[k][head[k]].addr;
          i_m_wdata[k*DW +: DW]    = reqs[k][head[k]].wdata;
        end else begin
          i_m_stb[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- slave responder ----------------
  // Acks each transaction after the planned number of stb cycles (lat),
  // or never when lat exceeds TIMEOUT's reach.
  initial begin
    resp_t cur;
    int    scnt;
    logic  active;
    active    = 1'b0;
    scnt      = 0;
    late_ack  = 1'b0;
    i_s_ack   = 1'b0;
    i_s_rdata = '0;
    cur       = '{NEVER, '0};
    forever begin
      @(posedge clk);
      #1;
      i_s_ack   = 1'b0;
      i_s_rdata = DW'($urandom);
      if (rst) begin
        active = 1'b0;
      end else if (o_s_stb) begin
        if (!active) begin
          active = 1'b1;
          scnt   = 0;
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else cur = '{NEVER, '0};
        end
        if (scnt == cur.lat) begin
          i_s_ack   = 1'b1;
          i_s_rdata = cur.data;
        end
        scnt++;
      end else begin
        active = 1'b0;
        if (late_ack) begin
          i_s_ack  = 1'b1;
          late_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_s_t        cur;
    logic [EW-1:0] e;
    int            dur;
    in_txn = 1'b0;
    dur    = 0;
    cur    = '{0, 1'b0, '0, '0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 1'b0;
      end else begin
        if (o_m_ack != '0) begin
          check("ack_onehot", 64'($onehot(o_m_ack)), 64'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 64'(o_m_ack), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_master", 64'(o_m_ack), 64'(3'b001 << e[EW-1 -: 2]));
            check("ack_err", 64'(o_m_err), e[DW] ? 64'(3'b001 << e[EW-1 -: 2]) : 64'd0);
            check("ack_rdata", 64'(o_m_rdata), 64'(e[DW-1:0]));
          end
        end
        if (o_s_stb && !in_txn) begin
          in_txn = 1'b1;
          dur    = 1;
          if (exp_s_q.size() == 0) begin
            check("unexpected_s_stb", 64'(o_s_stb), 64'd0);
            cur = '{0, o_s_wr_en, o_s_addr, o_s_wdata, 0};
          end else begin
            cur = exp_s_q.pop_front();
            check("grant", 64'(o_grant), 64'(3'b001 << cur.master));
            check("busy", 64'(o_busy), 64'd1);
          end
          check("s_wr_en", 64'(o_s_wr_en), 64'(cur.wr));
          check("s_addr", 64'(o_s_addr), 64'(cur.addr));
          check("s_wdata", 64'(o_s_wdata), 64'(cur.wdata));
        end else if (o_s_stb) begin
          dur++;
          check("s_stable", {31'd0, o_s_wr_en, o_s_addr}, {31'd0, cur.wr, cur.addr});
        end else if (in_txn) begin
          in_txn = 1'b0;
          check("s_stb_cycles", 64'(dur), 64'(cur.dur));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Plans a batch whose requests are all raised together: repeatedly grant the
  // first master with pending work, searching cyclically after the last grant.
  task automatic start_batch();
    int            rem[N];
    int            pos[N];
    int            total;
    int            t;
    int            k;
    logic          found;
    logic          err;
    logic [DW-1:0] rd;
    req_t          r;
    total = 0;
    t     = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = bcnt[i];
      pos[i] = 0;
      total += bcnt[i];
    end
    while (total > 0) begin
      found = 1'b0;
      k     = 0;
      for (int i = 1; i <= N; i++) begin
        if (!found && rem[(model_last + i) % N] > 0) begin
          found = 1'b1;
          k     = (model_last + i) % N;
        end
      end
      r   = reqs[k][pos[k]];
      err = (txn_lat[t] > TO);
      rd  = err ? '0 : txn_data[t];
      exp_s_q.push_back('{k, r.wr, r.addr, r.wdata, err ? TO + 1 : txn_lat[t] + 1});
      resp_q.push_back('{txn_lat[t], txn_data[t]});
      exp_q.push_back({2'(k), err, rd});
      model_last = k;
      rem[k]--;
      pos[k]++;
      total--;
      t++;
    end
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      cnt[i]  = bcnt[i];
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy || in_txn) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < 1000), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_req(input int k, input int slot, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    reqs[k][slot] = '{wr, addr, wdata};
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(0, 3);
    if (r == 6) return TO;
    if (r == 7) return NEVER;
    return 1;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst        = 1'b1;
    model_last = N - 1;
    repeat (2) @(negedge clk);
    check("rst_s_stb", 64'(o_s_stb), 64'd0);
    check("rst_grant", 64'(o_grant), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_m_ack", 64'(o_m_ack), 64'd0);
    check("rst_m_err", 64'(o_m_err), 64'd0);
    check("rst_m_rdata", 64'(o_m_rdata), 64'd0);
    check("rst_s_addr", 64'(o_s_addr), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read with a 3-cycle slave, including request-to-stb latency.
    bcnt = '{1, 0, 0};
    set_req(0, 0, 1'b0, 32'h100, 32'h0);
    txn_lat[0] = 3; txn_data[0] = 32'hCAFEF00D;
    start_batch();
    @(negedge clk);
    check("lat_stb_low_first", 64'(o_s_stb), 64'd0);
    @(negedge clk);
    check("lat_stb_high_next", 64'(o_s_stb), 64'd1);
    check("lat_addr", 64'(o_s_addr), 64'h100);
    wait_drain();

    // Write pass-through on master 1.
    bcnt = '{0, 1, 0};
    set_req(1, 0, 1'b1, 32'h2004, 32'h12345678);
    txn_lat[0] = 2; txn_data[0] = 32'h0BADBEEF;
    start_batch();
    wait_drain();

    // Contention: everyone busy, 1-cycle slave.
    bcnt = '{3, 3, 3};
    for (int k = 0; k < N; k++)
      for (int s = 0; s < 3; s++)
        set_req(k, s, 1'($urandom), AW'($urandom), DW'($urandom));
    for (int i = 0; i < 9; i++) begin
      txn_lat[i] = 0; txn_data[i] = DW'($urandom);
    end
    start_batch();
    wait_drain();

    // Timeout, then a late ack while idle must be ignored.
    bcnt = '{1, 0, 0};
    set_req(0, 0, 1'b0, 32'h300, 32'h0);
    txn_lat[0] = NEVER; txn_data[0] = 32'h11111111;
    start_batch();
    wait_drain();
    late_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_ignored", 64'(o_m_ack), 64'd0);
      check("late_ack_idle", 64'(o_busy), 64'd0);
    end

    // Ack lands in the expiry cycle: ack wins.
    bcnt = '{0, 0, 1};
    set_req(2, 0, 1'b0, 32'h400, 32'h0);
    txn_lat[0] = TO; txn_data[0] = 32'hA5A5A5A5;
    start_batch();
    wait_drain();

    // Asynchronous reset while BUSY.
    bcnt = '{0, 1, 0};
    set_req(1, 0, 1'b0, 32'h500, 32'h0);
    txn_lat[0] = NEVER; txn_data[0] = 32'h0;
    start_batch();
    t = 0;
    while (!o_s_stb && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_test_busy_reached", 64'(o_s_stb), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int k = 0; k < N; k++) cnt[k] = head[k];
    exp_q.delete();
    exp_s_q.delete();
    resp_q.delete();
    model_last = N - 1;
    #1;
    check("async_rst_s_stb", 64'(o_s_stb), 64'd0);
    check("async_rst_grant", 64'(o_grant), 64'd0);
    check("async_rst_busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_ack_after_rst", 64'(o_m_ack), 64'd0);
    end
    bcnt = '{1, 1, 0};
    set_req(0, 0, 1'b0, 32'h600, 32'h0);
    set_req(1, 0, 1'b0, 32'h604, 32'h0);
    txn_lat[0] = 1; txn_data[0] = 32'h60606060;
    txn_lat[1] = 1; txn_data[1] = 32'h61616161;
    start_batch();
    wait_drain();

    // Random batches.
    for (int b = 0; b < 12; b++) begin
      int tot;
      tot = 0;
      for (int k = 0; k < N; k++) begin
        bcnt[k] = $urandom_range(0, 4);
        tot += bcnt[k];
        for (int s = 0; s < bcnt[k]; s++)
          set_req(k, s, 1'($urandom), AW'($urandom), DW'($urandom));
      end
      if (tot == 0) begin
        bcnt[b % N] = 1;
        set_req(b % N, 0, 1'($urandom), AW'($urandom), DW'($urandom));
      end
      for (int i = 0; i < 16; i++) begin
        txn_lat[i]  = rand_lat();
        txn_data[i] = DW'($urandom);
      end
      start_batch();
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    fail_cnt++;
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-master to 1-slave memory-port arbiter using the core's stb/ack handshake.
- Generalises the fixed i-mem/d-mem split: several requesters (IF fetch, MEM load/store, debug/DMA) share one memory port.
- Round-robin grant, a registered request path and a per-transaction timeout that returns an error-ack if the slave never responds.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles o_s_stb may wait for i_s_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_m_stb  in  NUM_MASTERS  per-master request strobe, level, held until own ack.
- i_m_wr_en  in  NUM_MASTERS  per-master write enable (1=write, 0=read).
- i_m_addr  in  NUM_MASTERS*ADDR_W  flattened addresses, master k at [k*ADDR_W +: ADDR_W].
- i_m_wdata  in  NUM_MASTERS*DATA_W  flattened write data, same packing.
- o_m_ack  out  NUM_MASTERS  one-cycle completion pulse, at most one bit set.
- o_m_err  out  NUM_MASTERS  qualifies o_m_ack; 1 = timed out.
- o_m_rdata  out  DATA_W  shared read data, valid only with o_m_ack.
- o_s_stb  out  1  slave strobe.
- o_s_wr_en  out  1  slave write enable.
- o_s_addr  out  ADDR_W  slave address.
- o_s_wdata  out  DATA_W  slave write data.
- i_s_ack  in  1  slave completion.
- i_s_rdata  in  DATA_W  slave read data, sampled with i_s_ack.
- o_grant  out  NUM_MASTERS  one-hot current owner, 0 when idle.
- o_busy  out  1  1 while in BUSY.

Behaviour:
- Reset (async on rst high):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 has top priority first.
  - Timeout counter is 0.
- Reset mid-transaction: the transaction is dropped with no ack, and o_s_stb falls immediately (async).
- FSM states: IDLE, BUSY.
- IDLE:
  - The eligible set is i_m_stb & ~o_m_ack, which masks out a master being acked this cycle.
  - If the eligible set is non-zero, pick the first set bit searching cyclically from last+1.
  - On the next edge: register the winner's wr_en/addr/wdata onto o_s_*, set o_s_stb=1, o_grant=onehot(winner), o_busy=1, last=winner, counter=0, go to BUSY.
  - Latency: request seen at edge N means o_s_stb is high after edge N+1.
- BUSY:
  - o_s_* are held constant, so the slave sees stable signals regardless of master changes.
  - Counter increments each cycle that i_s_ack=0.
  - i_s_ack=1: on the next edge, o_m_ack[winner]=1, o_m_err=0, o_m_rdata=i_s_rdata (writes return the sampled i_s_rdata, which masters ignore). Also o_s_stb=0, o_grant=0, o_busy=0, go to IDLE.
  - Counter reaches TIMEOUT with i_s_ack=0 (TIMEOUT!=0): the same exit, but o_m_err[winner]=1 and o_m_rdata=0.
  - i_s_ack and expiry in the same cycle: ack wins, err=0.
- o_m_ack and o_m_err are single-cycle pulses and return to 0 the following cycle. o_m_rdata holds its last value.
- The ack cycle is an IDLE cycle, so another eligible master can be granted in it. This gives one bubble cycle of slave stb low between transactions.
- i_s_ack while in IDLE (late ack after a timeout) is ignored, with no master ack.
- A master dropping stb while granted has no effect; the transaction completes and the ack is still delivered.
- Width rules:
  - Counter width is clog2(TIMEOUT+1), minimum 1.
  - Pointer width is clog2(NUM_MASTERS).
  - No arithmetic on data.

Test Plan:
- Single read: m0 stb, addr=0x100. Slave acks 3 cycles after o_s_stb with rdata=0xCAFEF00D. Expect o_s_addr=0x100 one edge after the request, then o_m_ack=2'b01, o_m_err=0, o_m_rdata=0xCAFEF00D.
- Contention (NUM_MASTERS=3, all stb held, 1-cycle slave ack): grant order 0,1,2,0,… and never two o_m_ack bits set together.
- Write pass-through: m1 wr_en=1, addr=0x2004, wdata=0x12345678. Expect o_s_wr_en=1 and o_s_addr/wdata to match while o_s_stb=1, then ack=2'b10.
- Timeout (TIMEOUT=4, slave never acks): o_s_stb high exactly 5 cycles, then o_m_ack[0]=1, o_m_err[0]=1, o_m_rdata=0. A late i_s_ack in IDLE produces no ack.
- Ack and expiry coincide (TIMEOUT=4, slave acks in the expiry cycle, rdata=0xA5A5A5A5): ack with err=0 and rdata=0xA5A5A5A5.
- Async reset pulse while BUSY: o_s_stb and o_grant go to 0 without a clock edge, no ack is issued, and master 0 wins the next arbitration.
